// File: rtl/sdram_sample_buffer.sv
// SDRAM ring-buffer capture of a 16-bit stream, with oldest-first flow-controlled readback.
// Capture is a zero-latency pass-through; readback is credit-limited so rvalid can never overflow the FIFO.

// Registered FIFO: one cycle from push to non-empty; push when full is dropped; pop when empty is ignored.
module sample_fifo #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          empty,
  output logic          full
);
  logic [DW-1:0] mem [2**AW];
  logic [AW:0]   wp;
  logic [AW:0]   rp;

  assign empty    = (wp == rp);
  assign full     = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop_data = empty ? '0 : mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wp[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + (AW+1)'(1);
      if (pop && !empty) rp <= rp + (AW+1)'(1);
    end
  end
endmodule

module sdram_sample_buffer #(
  parameter int FIFO_AW      = 3,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [15:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        done,
  output logic        capturing,
  output logic        reading,
  output logic [24:0] sample_cnt,
  output logic [23:0] awaddr,
  output logic [15:0] wdata,
  output logic        wvalid,
  input  logic        wready,
  output logic [23:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [15:0] rdata,
  input  logic        rvalid
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_READ    = 2'd3;

  localparam int               DCW         = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DCW-1:0]   DRAIN_LAST  = DCW'(DRAIN_CYCLES - 1);
  localparam logic [FIFO_AW:0] CREDITS_MAX = (FIFO_AW+1)'(2**FIFO_AW);
  localparam logic [24:0]      CNT_SAT     = 25'h1000000;

  logic [1:0]       state;
  logic [23:0]      wr_ptr;
  logic [23:0]      rd_ptr;
  logic [24:0]      issue_rem;
  logic [FIFO_AW:0] credits;
  logic [DCW-1:0]   drain_cnt;
  logic             wr_hs;
  logic             ar_hs;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic             read_done;

  assign capturing = (state == S_CAPTURE);
  assign reading   = (state == S_DRAIN) || (state == S_READ);
  assign wvalid    = capturing && s_valid;
  assign s_ready   = capturing && wready;
  assign awaddr    = capturing ? wr_ptr : '0;
  assign wdata     = capturing ? s_data : '0;
  assign arvalid   = (state == S_READ) && (issue_rem != '0) && (credits != '0);
  assign araddr    = (state == S_READ) ? rd_ptr : '0;
  assign wr_hs     = wvalid && wready;
  assign ar_hs     = arvalid && arready;
  // Returns are only meaningful inside READ; stragglers from an abandoned readout are dropped.
  assign push      = (state == S_READ) && rvalid;
  assign m_valid   = !fifo_empty;
  assign pop       = m_valid && m_ready;
  assign read_done = (state == S_READ) && (issue_rem == '0) && (credits == CREDITS_MAX) && fifo_empty;

  sample_fifo #(.DW(16), .AW(FIFO_AW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (rdata),
    .pop       (pop),
    .pop_data  (m_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (rst_n && push) assert (!fifo_full);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      sample_cnt <= '0;
      issue_rem  <= '0;
      credits    <= CREDITS_MAX;
      drain_cnt  <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      credits <= credits - (FIFO_AW+1)'(ar_hs) + (FIFO_AW+1)'(pop);
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_CAPTURE;
            wr_ptr     <= '0;
            sample_cnt <= '0;
          end
        end
        S_CAPTURE: begin
          if (wr_hs) begin
            wr_ptr <= wr_ptr + 24'd1;
            if (sample_cnt != CNT_SAT) sample_cnt <= sample_cnt + 25'd1;
          end
          if (stop) begin
            state     <= S_DRAIN;
            drain_cnt <= '0;
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt + DCW'(1);
          if (drain_cnt == DRAIN_LAST) begin
            // Oldest surviving sample; when saturated the subtraction is a full lap and lands on wr_ptr.
            rd_ptr    <= wr_ptr - sample_cnt[23:0];
            issue_rem <= sample_cnt;
            if (sample_cnt == '0) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end else begin
              state <= S_READ;
            end
          end
        end
        S_READ: begin
          if (ar_hs) begin
            rd_ptr    <= rd_ptr + 24'd1;
            issue_rem <= issue_rem - 25'd1;
          end
          if (read_done) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_sample_buffer.sv
`timescale 1ns/1ps
module tb_sdram_sample_buffer;
  localparam int DRAIN_CYCLES = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        done;
  logic        capturing;
  logic        reading;
  logic [24:0] sample_cnt;
  logic [23:0] awaddr;
  logic [15:0] wdata;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [23:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [15:0] rdata;
  logic        rvalid;

  int n_cmp = 0;
  int n_bad = 0;

  // SDRAM model state
  int          lat = 2;
  int          now_c = 0;
  int          done_cnt = 0;
  logic [15:0] mem [bit [23:0]];
  bit   [23:0] aw_log[$];
  bit   [23:0] ar_log[$];
  bit   [23:0] rq_addr[$];
  int          rq_due[$];
  logic [15:0] cap_q[$];
  logic [15:0] out_q[$];

  always #5 clk = ~clk;

  sdram_sample_buffer #(.FIFO_AW(3), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .done(done), .capturing(capturing), .reading(reading), .sample_cnt(sample_cnt),
    .awaddr(awaddr), .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid)
  );

  // In-order SDRAM with fixed read latency; looks at the handshakes due on the coming edge.
  initial begin
    rvalid = 1'b0;
    rdata  = '0;
    forever begin
      @(negedge clk);
      #2;
      now_c++;
      if (wvalid && wready) begin
        mem[awaddr] = wdata;
        aw_log.push_back(awaddr);
      end
      if (arvalid && arready) begin
        ar_log.push_back(araddr);
        rq_addr.push_back(araddr);
        rq_due.push_back(now_c + lat);
      end
      if (done) done_cnt++;
      rvalid = 1'b0;
      if (rq_due.size() > 0 && rq_due[0] <= now_c) begin
        rvalid = 1'b1;
        rdata  = mem.exists(rq_addr[0]) ? mem[rq_addr[0]] : 16'hDEAD;
        void'(rq_due.pop_front());
        void'(rq_addr.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  function automatic int addr_diff(input bit [23:0] q[$], input bit [23:0] base, input int n);
    if (q.size() != n) return -2;
    for (int i = 0; i < n; i++) if (q[i] != base + 24'(i)) return i;
    return -1;
  endfunction

  function automatic int data_diff(input logic [15:0] a[$], input logic [15:0] b[$]);
    if (a.size() != b.size()) return -2;
    for (int i = 0; i < a.size(); i++) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_start;
    start = 1'b1; tick; start = 1'b0;
  endtask

  task automatic do_stop;
    stop = 1'b1; tick; stop = 1'b0;
  endtask

  task automatic drive_samples(input int stall);
    int i;
    int guard;
    i = 0; guard = 0;
    while (i < cap_q.size() && guard < 3000) begin
      s_valid = 1'b1;
      s_data  = cap_q[i];
      wready  = ($urandom_range(99) >= stall);
      #1;
      n_cmp++;
      if (s_ready !== wready || wvalid !== 1'b1 || wdata !== cap_q[i]) begin
        n_bad++;
        $display("FAIL capture_passthru: s_ready=%b wvalid=%b wdata=%h, want s_ready=%b wvalid=1 wdata=%h",
                 s_ready, wvalid, wdata, wready, cap_q[i]);
      end
      if (wready) i++;
      guard++;
      tick;
    end
    s_valid = 1'b0;
    wready  = 1'b0;
    n_cmp++;
    if (i != cap_q.size()) begin
      n_bad++;
      $display("FAIL capture_budget: accepted %0d, want %0d", i, cap_q.size());
    end
  endtask

  task automatic wait_first_ar(output int n);
    n = 0;
    while (!arvalid && n < 200) begin tick; n++; end
  endtask

  task automatic collect(input int max_cyc);
    int d0;
    int c;
    d0 = done_cnt; c = 0;
    out_q.delete();
    while (done_cnt == d0 && c < max_cyc) begin
      if (m_valid && m_ready) out_q.push_back(m_data);
      tick; c++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick; tick;
    n_cmp++;
    if ({m_data, m_valid, s_ready, done, capturing, reading, sample_cnt, awaddr, wdata, wvalid, araddr, arvalid} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: m_data=%h m_valid=%b s_ready=%b done=%b cnt=%h awaddr=%h araddr=%h arvalid=%b, want all 0",
               m_data, m_valid, s_ready, done, sample_cnt, awaddr, araddr, arvalid);
    end
    rst_n = 1'b1;
    tick;
    n_cmp++;
    if (capturing !== 1'b0 || reading !== 1'b0 || m_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: capturing=%b reading=%b m_valid=%b, want 0 0 0", capturing, reading, m_valid);
    end
  endtask

  task automatic test_basic;
    int n;
    int d;
    int d0;
    lat = 2; arready = 1'b1; m_ready = 1'b1;
    cap_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    aw_log.delete(); ar_log.delete();
    do_start;
    n_cmp++;
    if (capturing !== 1'b1 || reading !== 1'b0) begin
      n_bad++; $display("FAIL basic_capturing: capturing=%b reading=%b, want 1 0", capturing, reading);
    end
    drive_samples(0);
    n_cmp++;
    if (sample_cnt !== 25'd5) begin
      n_bad++; $display("FAIL basic_count: sample_cnt=%0d, want 5", sample_cnt);
    end
    d = addr_diff(aw_log, 24'h0, 5);
    n_cmp++;
    if (d != -1) begin
      n_bad++; $display("FAIL basic_awaddr: diff at %0d (size %0d), want 0..4", d, aw_log.size());
    end
    start = 1'b1; tick; start = 1'b0;
    n_cmp++;
    if (capturing !== 1'b1 || sample_cnt !== 25'd5 || awaddr !== 24'd5) begin
      n_bad++; $display("FAIL start_in_capture: capturing=%b cnt=%0d awaddr=%h, want 1 5 000005", capturing, sample_cnt, awaddr);
    end
    d0 = done_cnt;
    do_stop;
    wait_first_ar(n);
    n_cmp++;
    if (n != DRAIN_CYCLES || reading !== 1'b1) begin
      n_bad++; $display("FAIL basic_drain: first arvalid after %0d cycles reading=%b, want %0d 1", n, reading, DRAIN_CYCLES);
    end
    collect(300);
    d = data_diff(out_q, cap_q);
    n_cmp++;
    if (d != -1) begin
      n_bad++; $display("FAIL basic_mdata: diff at %0d (got %0d words), want 1111..5555", d, out_q.size());
    end
    d = addr_diff(ar_log, 24'h0, 5);
    n_cmp++;
    if (d != -1) begin
      n_bad++; $display("FAIL basic_araddr: diff at %0d (size %0d), want 0..4", d, ar_log.size());
    end
    tick; tick; tick;
    n_cmp++;
    if (done_cnt != d0 + 1 || capturing !== 1'b0 || reading !== 1'b0) begin
      n_bad++; $display("FAIL basic_done: pulses=%0d capturing=%b reading=%b, want 1 0 0", done_cnt - d0, capturing, reading);
    end
  endtask

  task automatic test_stalls;
    int n;
    int d;
    int d0;
    lat = 3; m_ready = 1'b1;
    cap_q.delete();
    for (int i = 0; i < 100; i++) cap_q.push_back(16'hA000 + 16'(i));
    aw_log.delete(); ar_log.delete();
    do_start;
    drive_samples(40);
    n_cmp++;
    if (sample_cnt !== 25'd100) begin
      n_bad++; $display("FAIL stall_count: sample_cnt=%0d, want 100", sample_cnt);
    end
    d = addr_diff(aw_log, 24'h0, 100);
    n_cmp++;
    if (d != -1) begin
      n_bad++; $display("FAIL stall_awaddr: diff at %0d (size %0d), want 0..99", d, aw_log.size());
    end
    d0 = done_cnt;
    do_stop;
    wait_first_ar(n);
    collect(2000);
    d = data_diff(out_q, cap_q);
    n_cmp++;
    if (d != -1 || done_cnt != d0 + 1) begin
      n_bad++; $display("FAIL stall_readout: diff at %0d (got %0d words) pulses=%0d, want all 100 in order, 1 pulse", d, out_q.size(), done_cnt - d0);
    end
  endtask

  task automatic test_credit_limit;
    int n;
    int d;
    lat = 6; m_ready = 1'b0;
    cap_q.delete();
    for (int i = 0; i < 12; i++) cap_q.push_back(16'hC000 + 16'(i));
    aw_log.delete(); ar_log.delete();
    do_start;
    drive_samples(0);
    do_stop;
    wait_first_ar(n);
    repeat (30) tick;
    n_cmp++;
    if (ar_log.size() != 8 || arvalid !== 1'b0 || m_valid !== 1'b1) begin
      n_bad++; $display("FAIL credit_stall: issued=%0d arvalid=%b m_valid=%b, want 8 0 1", ar_log.size(), arvalid, m_valid);
    end
    m_ready = 1'b1;
    collect(500);
    d = data_diff(out_q, cap_q);
    n_cmp++;
    if (d != -1) begin
      n_bad++; $display("FAIL credit_mdata: diff at %0d (got %0d words), want C000..C00B", d, out_q.size());
    end
    d = addr_diff(ar_log, 24'h0, 12);
    n_cmp++;
    if (d != -1) begin
      n_bad++; $display("FAIL credit_araddr: diff at %0d (size %0d), want 0..11", d, ar_log.size());
    end
  endtask

  task automatic test_wrap;
    int n;
    int d;
    lat = 2; m_ready = 1'b1;
    cap_q = '{16'hE001, 16'hE002, 16'hE003, 16'hE004};
    aw_log.delete(); ar_log.delete();
    do_start;
    force dut.wr_ptr = 24'hFFFFFE;
    tick;
    release dut.wr_ptr;
    drive_samples(0);
    d = addr_diff(aw_log, 24'hFFFFFE, 4);
    n_cmp++;
    if (d != -1 || sample_cnt !== 25'd4) begin
      n_bad++; $display("FAIL wrap_awaddr: diff at %0d (size %0d) cnt=%0d, want FFFFFE,FFFFFF,0,1 cnt 4", d, aw_log.size(), sample_cnt);
    end
    do_stop;
    wait_first_ar(n);
    collect(300);
    d = addr_diff(ar_log, 24'hFFFFFE, 4);
    n_cmp++;
    if (d != -1) begin
      n_bad++; $display("FAIL wrap_araddr: diff at %0d (size %0d), want FFFFFE,FFFFFF,0,1", d, ar_log.size());
    end
    d = data_diff(out_q, cap_q);
    n_cmp++;
    if (d != -1) begin
      n_bad++; $display("FAIL wrap_mdata: diff at %0d (got %0d words), want E001..E004", d, out_q.size());
    end
  endtask

  task automatic test_empty;
    int n;
    int d0;
    bit ar_seen;
    ar_log.delete();
    d0 = done_cnt;
    stop = 1'b1; tick; stop = 1'b0; tick;
    n_cmp++;
    if (capturing !== 1'b0 || reading !== 1'b0) begin
      n_bad++; $display("FAIL stop_in_idle: capturing=%b reading=%b, want 0 0", capturing, reading);
    end
    do_start;
    start = 1'b1; tick; start = 1'b0;
    n_cmp++;
    if (capturing !== 1'b1 || sample_cnt !== 25'd0) begin
      n_bad++; $display("FAIL empty_capture: capturing=%b cnt=%0d, want 1 0", capturing, sample_cnt);
    end
    do_stop;
    n = 0; ar_seen = 1'b0;
    while (!done && n < 200) begin
      if (arvalid) ar_seen = 1'b1;
      tick; n++;
    end
    n_cmp++;
    if (n != DRAIN_CYCLES || ar_seen) begin
      n_bad++; $display("FAIL empty_done: done after %0d cycles arvalid_seen=%0b, want %0d 0", n, ar_seen, DRAIN_CYCLES);
    end
    tick; tick; tick;
    n_cmp++;
    if (done_cnt != d0 + 1 || ar_log.size() != 0 || reading !== 1'b0) begin
      n_bad++; $display("FAIL empty_end: pulses=%0d reads=%0d reading=%b, want 1 0 0", done_cnt - d0, ar_log.size(), reading);
    end
  endtask

  task automatic test_reset_mid_read;
    int n;
    int d;
    lat = 6; m_ready = 1'b0;
    cap_q.delete();
    for (int i = 0; i < 10; i++) cap_q.push_back(16'h6000 + 16'(i));
    aw_log.delete(); ar_log.delete();
    do_start;
    drive_samples(0);
    do_stop;
    wait_first_ar(n);
    tick; tick; tick;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({m_data, m_valid, s_ready, done, capturing, reading, sample_cnt, awaddr, wdata, wvalid, araddr, arvalid} !== '0) begin
      n_bad++;
      $display("FAIL midread_reset: m_valid=%b reading=%b cnt=%h araddr=%h arvalid=%b, want all 0",
               m_valid, reading, sample_cnt, araddr, arvalid);
    end
    tick;
    rst_n = 1'b1;
    repeat (12) tick;
    n_cmp++;
    if (m_valid !== 1'b0 || reading !== 1'b0 || capturing !== 1'b0) begin
      n_bad++; $display("FAIL late_rvalid: m_valid=%b reading=%b capturing=%b, want 0 0 0", m_valid, reading, capturing);
    end
    m_ready = 1'b1; lat = 2;
    cap_q = '{16'h7001, 16'h7002};
    aw_log.delete(); ar_log.delete();
    do_start;
    drive_samples(0);
    d = addr_diff(aw_log, 24'h0, 2);
    n_cmp++;
    if (d != -1 || sample_cnt !== 25'd2) begin
      n_bad++; $display("FAIL restart_awaddr: diff at %0d (size %0d) cnt=%0d, want 0,1 cnt 2", d, aw_log.size(), sample_cnt);
    end
    do_stop;
    wait_first_ar(n);
    collect(300);
    d = data_diff(out_q, cap_q);
    n_cmp++;
    if (d != -1) begin
      n_bad++; $display("FAIL restart_mdata: diff at %0d (got %0d words), want 7001,7002", d, out_q.size());
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stalls;
    test_credit_limit;
    test_wrap;
    test_empty;
    test_reset_mid_read;
    repeat (3) tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
